systolic_scheduler: RTL and testbench
=====================================

// Module: systolic_scheduler
// PURPOSE
//  Sequencer that feeds the SIZE x SIZE systolic_array tile. A host loads operand matrix A
//  (row-wise) and B (row-wise) into internal row buffers, then pulses start. The block
//  clears the PE accumulators and streams A rows / B columns with diagonal skew on the
//  array edge inputs. It then raises done once every PE has consumed its last operand pair.
// PARAMETERS
//  SIZE   4   array dimension (matrices are SIZE x SIZE)
//  WIDTH  8   operand element width in bits
// PORTS
//  clk        in   1             rising-edge clock, single domain
//  reset      in   1             synchronous, active-low reset
//  wr_en      in   1             write one operand row this cycle (honoured in IDLE only)
//  wr_sel     in   1             0 = row of A, 1 = row of B
//  wr_row     in   $clog2(SIZE)  row index written
//  wr_data    in   SIZE*WIDTH    row elements; element c at [c*WIDTH +: WIDTH]
//  start      in   1             begin a multiply (honoured in IDLE only)
//  busy       out  1             high in CLEAR, FEED, DONE
//  done       out  1             one-cycle pulse: array results are final
//  sa_clear   out  1             one-cycle accumulator clear to the array
//  sa_enable  out  1             array advance enable, high throughout FEED
//  x_out      out  SIZE*WIDTH    row-edge operands; lane i -> array row i
//  w_out      out  SIZE*WIDTH    column-edge operands; lane j -> array column j
//  step       out  $clog2(3*SIZE) current FEED index k, 0 outside FEED
// BEHAVIOUR
//  - All outputs are registered. Under reset (reset==0 at an edge), the following hold:
//    state=IDLE; busy, done, sa_clear, sa_enable = 0; x_out, w_out, step = 0;
//    both row buffers are cleared to 0.
//  - FSM: IDLE -(start)-> CLEAR (1 cycle) -> FEED (3*SIZE-2 cycles) -> DONE (1 cycle) -> IDLE.
//  - Signal timing: sa_clear=1 only in CLEAR; sa_enable=1 only in FEED; done=1 only in DONE.
//  - Cycle n = n-th cycle after the edge that samples start: CLEAR in cycle 1,
//    FEED k=0..3*SIZE-3 in cycles 2..3*SIZE-1, done in cycle 3*SIZE (SIZE=4: done in cycle 12).
//  - FEED skew, for each k:
//      x_out lane i = A[i][k-i] if 0 <= k-i < SIZE, else 0
//      w_out lane j = B[k-j][j] if 0 <= k-j < SIZE, else 0
//    The trailing k = 2*SIZE-1 .. 3*SIZE-3 issue all-zero lanes to drain the array.
//  - Lanes are forced to 0 in IDLE, CLEAR and DONE. Values are raw copies; no arithmetic.
//  - wr_en in IDLE writes buffer[wr_sel][wr_row] at that edge.
//    wr_en outside IDLE is ignored, so buffers are frozen during a run.
//  - wr_en and start in the same IDLE cycle: the write commits and the run starts.
//    The new row is used, because CLEAR separates the write from the first FEED read.
//  - start while busy is ignored and is not queued. start held high re-triggers only after
//    DONE returns to IDLE; back-to-back runs have exactly one IDLE cycle between them.
//  - reset low mid-run: next cycle is IDLE with all outputs 0 and buffers 0. No done pulse.
//  - step counts 0..3*SIZE-3 with no wrap inside a run and returns to 0 on leaving FEED.
// TESTING
//  1 Skew: A[i][j]=4i+j+1, B=same, start -> at k=2 x_out lanes{0..3}={3,6,9,0},
//    w_out lanes{0..3}={9,6,3,0}; at k=6 both lanes {0,0,0,16}.
//  2 Latency: start pulse at cycle 0 -> sa_clear=1 in cycle 1; sa_enable=1 for cycles 2..11;
//    done=1 only in cycle 12; busy=0 again in cycle 13.
//  3 Integration with systolic_array: A=identity, B[r][c]=4r+c+1 ->
//    after done, array outputs y0..y15 = 1..16.
//  4 Busy protection: during FEED drive start=1 and wr_en with wr_data=all 0xFF ->
//    no restart, done exactly once, buffer contents unchanged on the next run.
//  5 Reset mid-run: reset=0 at k=4 -> next cycle all outputs 0 with busy=0;
//    a new run without reloading streams only zeros.
//  6 Same-cycle write+start: write A row0={7,7,7,7} with start -> at k=0 x_out lane0=7.

Source files
------------

// File: rtl/systolic_scheduler.sv
// systolic_scheduler: holds host-loaded operand matrices A and B in row
// buffers and, on start, clears the systolic array accumulators and streams
// A rows / B columns onto the array edges with diagonal skew. Trailing zero
// steps drain the array, and a one-cycle done pulse then marks the results
// as final.
module systolic_scheduler #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [$clog2(SIZE)-1:0]   wr_row,
    input  logic [SIZE*WIDTH-1:0]     wr_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      sa_clear,
    output logic                      sa_enable,
    output logic [SIZE*WIDTH-1:0]     x_out,
    output logic [SIZE*WIDTH-1:0]     w_out,
    output logic [$clog2(3*SIZE)-1:0] step
);

    localparam int STEP_W = $clog2(3*SIZE);
    localparam logic [STEP_W-1:0] LAST_K = STEP_W'(3*SIZE-3);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        DONE
    } state_t;

    state_t state;

    // Row buffers: a_buf[r] holds row r of A, b_buf[r] holds row r of B.
    logic [SIZE*WIDTH-1:0] a_buf [SIZE];
    logic [SIZE*WIDTH-1:0] b_buf [SIZE];

    logic [STEP_W-1:0]     next_k;
    logic [SIZE*WIDTH-1:0] feed_x;
    logic [SIZE*WIDTH-1:0] feed_w;

    // Feed index that the registered lanes will present in the coming cycle.
    // It is 0 when leaving CLEAR and step+1 while FEED continues.
    always_comb begin
        next_k = '0;
        if (state == FEED) begin
            next_k = step + 1'b1;
        end
    end

    // Diagonal skew for index next_k. Row lane i carries A[i][c] where
    // i + c == next_k. Column lane j carries B[r][j] where r + j == next_k.
    // Indices beyond 2*SIZE-2 match nothing, so the drain steps are all zero.
    always_comb begin
        feed_x = '0;
        feed_w = '0;
        for (int i = 0; i < SIZE; i++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (int'(next_k) == i + c) begin
                    feed_x[i*WIDTH +: WIDTH] = a_buf[i][c*WIDTH +: WIDTH];
                end
            end
        end
        for (int j = 0; j < SIZE; j++) begin
            for (int r = 0; r < SIZE; r++) begin
                if (int'(next_k) == r + j) begin
                    feed_w[j*WIDTH +: WIDTH] = b_buf[r][j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Host writes land only in IDLE, so the buffers stay frozen for a whole run.
    // A write in the same cycle as start still commits before the first FEED read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < SIZE; r++) begin
                a_buf[r] <= '0;
                b_buf[r] <= '0;
            end
        end else if (state == IDLE && wr_en) begin
            if (wr_sel) begin
                b_buf[wr_row] <= wr_data;
            end else begin
                a_buf[wr_row] <= wr_data;
            end
        end
    end

    // Run sequencer: IDLE -> CLEAR -> FEED (3*SIZE-2 steps) -> DONE -> IDLE.
    // Every output is registered here. start is looked at only in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sa_clear  <= 1'b0;
            sa_enable <= 1'b0;
            x_out     <= '0;
            w_out     <= '0;
            step      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    sa_enable <= 1'b0;
                    x_out     <= '0;
                    w_out     <= '0;
                    step      <= '0;
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        sa_clear <= 1'b1;
                    end else begin
                        busy     <= 1'b0;
                        sa_clear <= 1'b0;
                    end
                end
                CLEAR: begin
                    state     <= FEED;
                    sa_clear  <= 1'b0;
                    sa_enable <= 1'b1;
                    step      <= '0;
                    x_out     <= feed_x;
                    w_out     <= feed_w;
                end
                FEED: begin
                    if (step == LAST_K) begin
                        state     <= DONE;
                        sa_enable <= 1'b0;
                        done      <= 1'b1;
                        step      <= '0;
                        x_out     <= '0;
                        w_out     <= '0;
                    end else begin
                        step  <= next_k;
                        x_out <= feed_x;
                        w_out <= feed_w;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    sa_clear  <= 1'b0;
                    sa_enable <= 1'b0;
                    x_out     <= '0;
                    w_out     <= '0;
                    step      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_scheduler.sv
// tb_systolic_scheduler: directed and randomized runs of systolic_scheduler,
// checked cycle by cycle against a matrix-level reference model of the
// skewed operand stream and the run timing.
module tb_systolic_scheduler;

    localparam int SIZE  = 4;
    localparam int WIDTH = 8;
    localparam int RUN_N = 3*SIZE + 1;

    logic                      clk;
    logic                      reset;
    logic                      wr_en;
    logic                      wr_sel;
    logic [$clog2(SIZE)-1:0]   wr_row;
    logic [SIZE*WIDTH-1:0]     wr_data;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      sa_clear;
    logic                      sa_enable;
    logic [SIZE*WIDTH-1:0]     x_out;
    logic [SIZE*WIDTH-1:0]     w_out;
    logic [$clog2(3*SIZE)-1:0] step;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference copies of the operand matrices, held element by element.
    logic [WIDTH-1:0] ma [SIZE][SIZE];
    logic [WIDTH-1:0] mb [SIZE][SIZE];

    systolic_scheduler #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .sa_clear  (sa_clear),
        .sa_enable (sa_enable),
        .x_out     (x_out),
        .w_out     (w_out),
        .step      (step)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one row write for a single cycle; the model follows only when
    // the scheduler is expected to be idle.
    task automatic applyStimulus(input bit sel, input int row, input logic [SIZE*WIDTH-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = row[$clog2(SIZE)-1:0];
        wr_data = data;
        for (int c = 0; c < SIZE; c++) begin
            if (sel) mb[row][c] = data[c*WIDTH +: WIDTH];
            else     ma[row][c] = data[c*WIDTH +: WIDTH];
        end
        tick();
        wr_en = 1'b0;
    endtask

    function automatic logic [SIZE*WIDTH-1:0] expX(input int k);
        logic [SIZE*WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (k - i >= 0 && k - i < SIZE) v[i*WIDTH +: WIDTH] = ma[i][k-i];
        end
        return v;
    endfunction

    function automatic logic [SIZE*WIDTH-1:0] expW(input int k);
        logic [SIZE*WIDTH-1:0] v;
        v = '0;
        for (int j = 0; j < SIZE; j++) begin
            if (k - j >= 0 && k - j < SIZE) v[j*WIDTH +: WIDTH] = mb[k-j][j];
        end
        return v;
    endfunction

    // Expected outputs in cycle n after the edge that sampled start.
    task automatic checkCycle(input string tag, input int n);
        bit in_feed;
        int k;
        in_feed = (n >= 2) && (n <= 3*SIZE - 1);
        k = in_feed ? n - 2 : 0;
        checkOutput($sformatf("%s_n%0d_busy", tag, n),   64'(busy),      64'(n <= 3*SIZE));
        checkOutput($sformatf("%s_n%0d_clear", tag, n),  64'(sa_clear),  64'(n == 1));
        checkOutput($sformatf("%s_n%0d_enable", tag, n), 64'(sa_enable), 64'(in_feed));
        checkOutput($sformatf("%s_n%0d_done", tag, n),   64'(done),      64'(n == 3*SIZE));
        checkOutput($sformatf("%s_n%0d_step", tag, n),   64'(step),      64'(k));
        checkOutput($sformatf("%s_n%0d_x", tag, n),      64'(x_out),     in_feed ? 64'(expX(k)) : 64'd0);
        checkOutput($sformatf("%s_n%0d_w", tag, n),      64'(w_out),     in_feed ? 64'(expW(k)) : 64'd0);
    endtask

    // One full run. junkK >= 0 injects start plus an all-ones write at that
    // feed step; withWrite issues an A/B row write in the start cycle.
    task automatic runCheck(input string tag, input int junkK, input bit withWrite,
                            input bit wsel, input int wrow, input logic [SIZE*WIDTH-1:0] wdata);
        start = 1'b1;
        if (withWrite) begin
            wr_en   = 1'b1;
            wr_sel  = wsel;
            wr_row  = wrow[$clog2(SIZE)-1:0];
            wr_data = wdata;
            for (int c = 0; c < SIZE; c++) begin
                if (wsel) mb[wrow][c] = wdata[c*WIDTH +: WIDTH];
                else      ma[wrow][c] = wdata[c*WIDTH +: WIDTH];
            end
        end
        for (int n = 1; n <= RUN_N; n++) begin
            tick();
            start = 1'b0;
            wr_en = 1'b0;
            checkCycle(tag, n);
            if (junkK >= 0 && n - 2 == junkK) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_sel  = 1'($urandom_range(0, 1));
                wr_row  = 2'($urandom_range(0, SIZE-1));
                wr_data = '1;
            end
        end
    endtask

    initial begin
        logic [SIZE*WIDTH-1:0] row;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_row  = '0;
        wr_data = '0;
        start   = 1'b0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end

        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_clear", 64'(sa_clear), 64'd0);
        checkOutput("rst_enable", 64'(sa_enable), 64'd0);
        checkOutput("rst_x", 64'(x_out), 64'd0);
        checkOutput("rst_w", 64'(w_out), 64'd0);
        checkOutput("rst_step", 64'(step), 64'd0);
        reset = 1'b1;
        tick();

        $display("[TB] skew pattern A=B=4i+j+1");
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) row[c*WIDTH +: WIDTH] = WIDTH'(4*r + c + 1);
            applyStimulus(1'b0, r, row);
            applyStimulus(1'b1, r, row);
        end
        checkOutput("idle_write_busy", 64'(busy), 64'd0);
        runCheck("skew", -1, 1'b0, 1'b0, 0, '0);

        $display("[TB] random matrices, back-to-back runs");
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < SIZE; r++) begin
                applyStimulus(1'b0, r, $urandom);
                applyStimulus(1'b1, r, $urandom);
            end
            runCheck($sformatf("rand%0d", t), -1, 1'b0, 1'b0, 0, '0);
            runCheck($sformatf("b2b%0d", t), -1, 1'b0, 1'b0, 0, '0);
        end

        $display("[TB] busy protection");
        runCheck("busy_a", 3, 1'b0, 1'b0, 0, '0);
        runCheck("busy_b", 6, 1'b0, 1'b0, 0, '0);
        tick();
        checkOutput("busy_noqueue", 64'(busy), 64'd0);
        runCheck("busy_rerun", -1, 1'b0, 1'b0, 0, '0);

        $display("[TB] same-cycle write and start");
        runCheck("wrstart", -1, 1'b1, 1'b0, 0, {SIZE{8'd7}});
        runCheck("wrstartB", -1, 1'b1, 1'b1, $urandom_range(0, SIZE-1), $urandom);

        $display("[TB] reset mid-run");
        start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            start = 1'b0;
            checkCycle("midrst", n);
        end
        reset = 1'b0;
        tick();
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_enable", 64'(sa_enable), 64'd0);
        checkOutput("midrst_clear", 64'(sa_clear), 64'd0);
        checkOutput("midrst_x", 64'(x_out), 64'd0);
        checkOutput("midrst_w", 64'(w_out), 64'd0);
        checkOutput("midrst_step", 64'(step), 64'd0);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        reset = 1'b1;
        tick();
        checkOutput("midrst_nodone", 64'(done), 64'd0);
        runCheck("postrst", -1, 1'b0, 1'b0, 0, '0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
